// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/RV64I decode stage with load-use stall, flush and illegal detection
module rv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_code,
  output logic            out_alu_src_a,
  output logic [1:0]      out_alu_src_b,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic            out_reg_write,
  output logic            out_jump,
  output logic            out_jalr,
  output logic            out_branch,
  output logic            out_illegal
);
  localparam int SH = (XLEN == 64) ? 6 : 5;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_code;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic            illegal;
  } bundle_t;
  bundle_t bundle_d, bundle_q, dec;
  logic valid_d, valid_q;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_shift;
  logic ill, uses_rs1, uses_rs2, hazard, free, accept;
  logic [3:0] alu_f;
  logic signed [31:0] imm32;
  assign op       = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign is_r     = op == 7'b0110011;
  assign is_i     = op == 7'b0010011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_br    = op == 7'b1100011;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_shift = is_i && (f3 == 3'b001 || f3 == 3'b101);
  assign uses_rs1 = is_r || is_i || is_ld || is_st || is_br || is_jalr;
  assign uses_rs2 = is_r || is_st || is_br;
  assign hazard   = ex_mem_read && ex_rd != 5'd0 &&
                    ((uses_rs1 && in_instr[19:15] == ex_rd) || (uses_rs2 && in_instr[24:20] == ex_rd));
  assign free     = !valid_q || out_ready;
  assign in_ready = !reset && !flush && !hazard && free;
  assign accept   = in_valid && in_ready;
  assign ill = !(is_r || is_i || is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_auipc) ||
               (is_r && !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))) ||
               (XLEN == 32 && is_shift && in_instr[25]);
  // instr[30] only distinguishes sub (R-type) and sra/srai
  always_comb begin
    alu_f = f3 == 3'b000 ? ((is_r && in_instr[30]) ? 4'd1 : 4'd0) :
            f3 == 3'b001 ? 4'd6 :
            f3 == 3'b010 ? 4'd9 :
            f3 == 3'b011 ? 4'd10 :
            f3 == 3'b100 ? 4'd4 :
            f3 == 3'b101 ? (in_instr[30] ? 4'd8 : 4'd7) :
            f3 == 3'b110 ? 4'd5 : 4'd3;
    imm32 = is_shift ? {{(32-SH){1'b0}}, in_instr[20 +: SH]} :
            (is_i || is_ld || is_jalr) ? {{20{in_instr[31]}}, in_instr[31:20]} :
            is_st ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            is_br ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
            (is_lui || is_auipc) ? {in_instr[31:12], 12'b0} :
            is_jal ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} : 32'sd0;
  end
  always_comb begin
    dec            = '0;
    dec.pc         = in_pc;
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.rd         = in_instr[11:7];
    dec.funct3     = f3;
    dec.imm        = XLEN'(imm32);
    dec.alu_code   = is_lui ? 4'd2 : (is_r || is_i) ? alu_f : is_br ? 4'd1 : 4'd0;
    dec.alu_src_a  = is_jal || is_jalr || is_auipc;
    dec.alu_src_b  = (is_jal || is_jalr) ? 2'b10 : (is_r || is_br) ? 2'b00 : 2'b01;
    dec.mem_read   = !ill && is_ld;
    dec.mem_write  = !ill && is_st;
    dec.mem_to_reg = is_ld;
    dec.reg_write  = !ill && (is_r || is_i || is_ld || is_jalr || is_lui || is_auipc || is_jal);
    dec.jump       = !ill && (is_jal || is_jalr);
    dec.jalr       = is_jalr;
    dec.branch     = !ill && is_br;
    dec.illegal    = ill;
  end
  // flush and bubbles both leave a fully zeroed NOP behind
  always_comb begin
    valid_d  = accept ? 1'b1 : (flush || free) ? 1'b0 : valid_q;
    bundle_d = accept ? dec : (flush || free) ? bundle_t'('0) : bundle_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end
  assign out_valid      = valid_q;
  assign out_pc         = bundle_q.pc;
  assign out_rs1        = bundle_q.rs1;
  assign out_rs2        = bundle_q.rs2;
  assign out_rd         = bundle_q.rd;
  assign out_funct3     = bundle_q.funct3;
  assign out_imm        = bundle_q.imm;
  assign out_alu_code   = bundle_q.alu_code;
  assign out_alu_src_a  = bundle_q.alu_src_a;
  assign out_alu_src_b  = bundle_q.alu_src_b;
  assign out_mem_read   = bundle_q.mem_read;
  assign out_mem_write  = bundle_q.mem_write;
  assign out_mem_to_reg = bundle_q.mem_to_reg;
  assign out_reg_write  = bundle_q.reg_write;
  assign out_jump       = bundle_q.jump;
  assign out_jalr       = bundle_q.jalr;
  assign out_branch     = bundle_q.branch;
  assign out_illegal    = bundle_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed checks of the decode stage at XLEN=64
module tb_rv_decode_stage;
  logic        clk = 0;
  logic        reset, flush, in_valid, in_ready, ex_mem_read, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [4:0]  ex_rd, out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_code;
  logic        out_alu_src_a;
  logic [1:0]  out_alu_src_b;
  logic        out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
  logic        out_jump, out_jalr, out_branch, out_illegal;
  int checks = 0;
  int errors = 0;
  rv_decode_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3), .out_imm(out_imm),
    .out_alu_code(out_alu_code), .out_alu_src_a(out_alu_src_a), .out_alu_src_b(out_alu_src_b),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .out_jump(out_jump), .out_jalr(out_jalr),
    .out_branch(out_branch), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 64'(out_valid), 64'd0);
    chk({tag, " rd"}, 64'(out_rd), 64'd0);
    chk({tag, " rs1"}, 64'(out_rs1), 64'd0);
    chk({tag, " imm"}, out_imm, 64'd0);
    chk({tag, " pc"}, out_pc, 64'd0);
    chk({tag, " regw"}, 64'(out_reg_write), 64'd0);
  endtask
  initial begin
    reset = 1; flush = 0; in_valid = 1; out_ready = 1; ex_mem_read = 0; ex_rd = 0;
    in_instr = 32'h002081B3; in_pc = 64'h100;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("reset valid c1", 64'(out_valid), 64'd0);
    tick();
    chk_zero("reset");
    chk("reset alu_src_b", 64'(out_alu_src_b), 64'd0);
    reset = 0;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("add valid", 64'(out_valid), 64'd1);
    chk("add rd", 64'(out_rd), 64'd3);
    chk("add rs1", 64'(out_rs1), 64'd1);
    chk("add rs2", 64'(out_rs2), 64'd2);
    chk("add alu", 64'(out_alu_code), 64'd0);
    chk("add srcb", 64'(out_alu_src_b), 64'd0);
    chk("add regw", 64'(out_reg_write), 64'd1);
    chk("add pc", out_pc, 64'h100);
    in_instr = 32'h402081B3; in_pc = 64'h104;
    tick();
    chk("sub alu", 64'(out_alu_code), 64'd1);
    chk("sub illegal", 64'(out_illegal), 64'd0);
    in_instr = 32'hFFF00093; in_pc = 64'h108;
    tick();
    chk("addi imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("addi srcb", 64'(out_alu_src_b), 64'd1);
    chk("addi rd", 64'(out_rd), 64'd1);
    in_instr = 32'h40335293;
    tick();
    chk("srai alu", 64'(out_alu_code), 64'd8);
    chk("srai imm", out_imm, 64'd3);
    chk("srai rs1", 64'(out_rs1), 64'd6);
    in_instr = 32'h010000EF;
    tick();
    chk("jal imm", out_imm, 64'd16);
    chk("jal jump", 64'(out_jump), 64'd1);
    chk("jal srca", 64'(out_alu_src_a), 64'd1);
    chk("jal srcb", 64'(out_alu_src_b), 64'd2);
    chk("jal regw", 64'(out_reg_write), 64'd1);
    in_instr = 32'h0080A283;
    tick();
    chk("lw imm", out_imm, 64'd8);
    chk("lw mem_read", 64'(out_mem_read), 64'd1);
    chk("lw mem_to_reg", 64'(out_mem_to_reg), 64'd1);
    chk("lw funct3", 64'(out_funct3), 64'd2);
    in_instr = 32'hFE20AE23;
    tick();
    chk("sw imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("sw mem_write", 64'(out_mem_write), 64'd1);
    chk("sw regw", 64'(out_reg_write), 64'd0);
    in_instr = 32'h00208463;
    tick();
    chk("beq branch", 64'(out_branch), 64'd1);
    chk("beq alu", 64'(out_alu_code), 64'd1);
    chk("beq imm", out_imm, 64'd8);
    in_instr = 32'h800002B7;
    tick();
    chk("lui imm", out_imm, 64'hFFFFFFFF80000000);
    chk("lui alu", 64'(out_alu_code), 64'd2);
    in_valid = 0;
    tick();
    chk("idle bubble valid", 64'(out_valid), 64'd0);
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 64'h200;
    ex_mem_read = 1; ex_rd = 5'd1;
    #1;
    chk("hazard in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_zero("hazard bubble");
    ex_mem_read = 0;
    #1;
    chk("hazard clear in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("after stall valid", 64'(out_valid), 64'd1);
    chk("after stall rd", 64'(out_rd), 64'd3);
    ex_mem_read = 1; ex_rd = 5'd0;
    #1;
    chk("ex_rd zero in_ready", 64'(in_ready), 64'd1);
    ex_mem_read = 0;
    in_instr = 32'h0080A283; in_pc = 64'h300;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold valid", 64'(out_valid), 64'd1);
      chk("hold rd", 64'(out_rd), 64'd3);
      chk("hold pc", out_pc, 64'h200);
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    flush = 1;
    #1;
    chk("flush in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_zero("flush");
    flush = 0; out_ready = 1;
    in_instr = 32'h0000007F;
    tick();
    chk("illegal valid", 64'(out_valid), 64'd1);
    chk("illegal flag", 64'(out_illegal), 64'd1);
    chk("illegal regw", 64'(out_reg_write), 64'd0);
    in_instr = 32'h00000000;
    tick();
    chk("zero instr illegal", 64'(out_illegal), 64'd1);
    chk("zero instr mem_read", 64'(out_mem_read), 64'd0);
    in_valid = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
